// File: rtl/imem_prefetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | imem_prefetch_ctrl: dual-port instruction prefetch queue with redirect  |
// | and halt/drain. Optional stats counters via IMEM_PREFETCH_STATS_EN.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module imem_prefetch_ctrl #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addra,
  input  logic [DATA_W-1:0] imem_douta,
  output logic [ADDR_W-1:0] imem_addrb,
  input  logic [DATA_W-1:0] imem_doutb,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              out_ready,
  output logic              busy,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       redir_cnt
);

  localparam int              c_PW    = $clog2(DEPTH);
  localparam logic [c_PW:0]   c_DEPTH = (c_PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [c_PW:0]     r_count;
  logic [c_PW:0]     w_free;
  logic [c_PW-1:0]   r_rd_ptr, r_wr_ptr, w_wr_ptr_b;
  logic [ADDR_W-1:0] r_q_addr [DEPTH];
  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [1:0]        w_npush;
  logic              w_pop;
  logic [ADDR_W-1:0] w_pc_b;

  assign w_pc_b     = r_fetch_pc + ADDR_W'(1);
  assign w_wr_ptr_b = r_wr_ptr + c_PW'(1);
  assign imem_addra = r_fetch_pc;
  assign imem_addrb = w_pc_b;
  assign out_valid  = (r_count != '0);
  assign out_addr   = out_valid ? r_q_addr[r_rd_ptr] : '0;
  assign out_data   = out_valid ? r_q_data[r_rd_ptr] : '0;
  assign busy       = (r_state == ST_RUN);

  // Free slots deliberately ignore this cycle's pop.
  always_comb begin
    w_free  = c_DEPTH - r_count;
    w_npush = 2'd0;
    if (!redirect_valid && r_state == ST_RUN) begin
      if (w_free >= (c_PW+1)'(2))
        w_npush = 2'd2;
      else if (w_free == (c_PW+1)'(1))
        w_npush = 2'd1;
    end
    w_pop = out_valid & out_ready & ~redirect_valid;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (redirect_valid) w_state_nxt = ST_RUN;
      ST_RUN:   if (halt) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (!halt) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= redirect_addr;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(w_npush);
        r_count    <= r_count + (c_PW+1)'(w_npush) - (c_PW+1)'(w_pop);
        r_rd_ptr   <= r_rd_ptr + c_PW'(w_pop);
        r_wr_ptr   <= r_wr_ptr + c_PW'(w_npush);
      end
    end
  end

  // Storage needs no reset: out_* are masked by out_valid.
  always_ff @(posedge clk) begin
    if (w_npush != 2'd0) begin
      r_q_addr[r_wr_ptr] <= r_fetch_pc;
      r_q_data[r_wr_ptr] <= imem_douta;
    end
    if (w_npush == 2'd2) begin
      r_q_addr[w_wr_ptr_b] <= w_pc_b;
      r_q_data[w_wr_ptr_b] <= imem_doutb;
    end
  end

`ifdef IMEM_PREFETCH_STATS_EN
  logic [31:0] r_fetch_cnt, r_redir_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_fetch_cnt <= r_fetch_cnt + 32'(w_npush);
      if (redirect_valid)
        r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign redir_cnt = r_redir_cnt;
`else
  assign fetch_cnt = '0;
  assign redir_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_prefetch_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_imem_prefetch_ctrl: randomized and directed bench with a queue-based |
// | reference model of the prefetch controller. Revision: 1.0              |
// +------------------------------------------------------------------------+
module tb_imem_prefetch_ctrl;

  localparam int c_DEPTH = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] imem_addra, imem_addrb, redirect_addr = '0, out_addr;
  logic [63:0] imem_douta, imem_doutb, out_data;
  logic        redirect_valid = 1'b0, halt = 1'b0, out_ready = 1'b0;
  logic        out_valid, busy;
  logic [31:0] fetch_cnt, redir_cnt;

  logic [63:0] mem [16384];
  assign imem_douta = mem[imem_addra];
  assign imem_doutb = mem[imem_addrb];

  imem_prefetch_ctrl #(.ADDR_W(14), .DATA_W(64), .DEPTH(c_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_addra(imem_addra), .imem_douta(imem_douta),
    .imem_addrb(imem_addrb), .imem_doutb(imem_doutb),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .halt(halt), .out_valid(out_valid), .out_data(out_data),
    .out_addr(out_addr), .out_ready(out_ready), .busy(busy),
    .fetch_cnt(fetch_cnt), .redir_cnt(redir_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain queue of {addr,data} plus PC/mode/counters.
  logic [13:0] q_addr [$];
  logic [63:0] q_data [$];
  int          m_state;
  logic [13:0] m_pc;
  logic [31:0] m_fc, m_rc;

  task automatic model_reset();
    q_addr.delete(); q_data.delete();
    m_state = S_IDLE; m_pc = '0; m_fc = '0; m_rc = '0;
  endtask

  function automatic logic e_valid();
    return q_addr.size() != 0;
  endfunction

  function automatic logic [31:0] e_fc();
`ifdef IMEM_PREFETCH_STATS_EN
    return m_fc;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] e_rc();
`ifdef IMEM_PREFETCH_STATS_EN
    return m_rc;
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of inputs, advance the model, sample after the edge.
  task automatic step(input logic redir, input logic [13:0] ra, input logic hlt, input logic rdy);
    int free, n;
    logic pop;
    @(negedge clk);
    redirect_valid = redir; redirect_addr = ra; halt = hlt; out_ready = rdy;
    free = c_DEPTH - q_addr.size();
    pop  = (q_addr.size() != 0) && rdy;
    if (redir) begin
      q_addr.delete(); q_data.delete();
      m_pc = ra; m_rc = m_rc + 1;
      m_state = (m_state == S_IDLE || !hlt) ? S_RUN : S_DRAIN;
    end else begin
      n = (m_state == S_RUN) ? ((free >= 2) ? 2 : free) : 0;
      if (pop) begin
        void'(q_addr.pop_front()); void'(q_data.pop_front());
      end
      for (int k = 0; k < n; k++) begin
        q_addr.push_back(m_pc); q_data.push_back(mem[m_pc]);
        m_pc = m_pc + 14'd1;
      end
      m_fc = m_fc + 32'(n);
      if (m_state == S_RUN && hlt) m_state = S_DRAIN;
      else if (m_state == S_DRAIN && !hlt) m_state = S_RUN;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    n_vec++; if (out_data !== 64'd0) begin n_err++; $display("FAIL rst_data: got %h want 0", out_data); end
    n_vec++; if (out_addr !== 14'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", out_addr); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (imem_addra !== 14'd0 || imem_addrb !== 14'd1) begin
      n_err++; $display("FAIL rst_addrs: got %h/%h want 0000/0001", imem_addra, imem_addrb); end
    n_vec++; if (fetch_cnt !== 32'd0 || redir_cnt !== 32'd0) begin
      n_err++; $display("FAIL rst_cnt: got %0d/%0d want 0/0", fetch_cnt, redir_cnt); end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_sequential();
    step(1'b1, 14'h0010, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL seq_lat1: valid got %b want 0", out_valid); end
    n_vec++; if (imem_addra !== 14'h0010) begin n_err++; $display("FAIL seq_addra: got %h want 0010", imem_addra); end
    step(1'b0, 14'h0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      n_vec++; if (out_valid !== 1'b1 || out_addr !== 14'(16 + k)) begin
        n_err++; $display("FAIL seq_head%0d: valid %b addr %h want 1 %h", k, out_valid, out_addr, 14'(16 + k)); end
      n_vec++; if (out_data !== mem[14'(16 + k)]) begin
        n_err++; $display("FAIL seq_data%0d: got %h want %h", k, out_data, mem[14'(16 + k)]); end
      step(1'b0, 14'h0, 1'b0, 1'b1);
    end
    n_vec++; if (fetch_cnt !== e_fc() || redir_cnt !== e_rc()) begin
      n_err++; $display("FAIL seq_cnt: got %0d/%0d want %0d/%0d", fetch_cnt, redir_cnt, e_fc(), e_rc()); end
  endtask

  task automatic test_backpressure();
    step(1'b1, 14'h0100, 1'b0, 1'b0);
    repeat (5) step(1'b0, 14'h0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_addr !== 14'h0100) begin
      n_err++; $display("FAIL bp_head: valid %b addr %h want 1 0100", out_valid, out_addr); end
    n_vec++; if (imem_addra !== 14'h0104) begin n_err++; $display("FAIL bp_pc: got %h want 0104", imem_addra); end
    n_vec++; if (q_addr.size() != 4) begin n_err++; $display("FAIL bp_model_fill: got %0d want 4", q_addr.size()); end
    for (int k = 0; k < 8; k++) begin
      n_vec++; if (out_valid !== 1'b1 || out_addr !== 14'(14'h0100 + k) || out_data !== mem[14'(14'h0100 + k)]) begin
        n_err++; $display("FAIL bp_seq%0d: valid %b addr %h want 1 %h", k, out_valid, out_addr, 14'(14'h0100 + k)); end
      step(1'b0, 14'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 14'h3FFE, 1'b0, 1'b1);
    n_vec++; if (imem_addrb !== 14'h3FFF) begin n_err++; $display("FAIL wrap_addrb: got %h want 3fff", imem_addrb); end
    step(1'b0, 14'h0, 1'b0, 1'b1);
    n_vec++; if (imem_addra !== 14'h0000) begin n_err++; $display("FAIL wrap_pc: got %h want 0000", imem_addra); end
    for (int k = 0; k < 4; k++) begin
      n_vec++; if (out_valid !== 1'b1 || out_addr !== 14'(14'h3FFE + k) || out_data !== mem[14'(14'h3FFE + k)]) begin
        n_err++; $display("FAIL wrap_seq%0d: valid %b addr %h want 1 %h", k, out_valid, out_addr, 14'(14'h3FFE + k)); end
      step(1'b0, 14'h0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_mid_redirect();
    step(1'b1, 14'h0050, 1'b0, 1'b1);
    repeat (4) step(1'b0, 14'h0, 1'b0, 1'b1);
    step(1'b1, 14'h0200, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_gap: valid got %b want 0", out_valid); end
    n_vec++; if (redir_cnt !== e_rc()) begin n_err++; $display("FAIL mid_redir_cnt: got %0d want %0d", redir_cnt, e_rc()); end
    step(1'b0, 14'h0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b1 || out_addr !== 14'h0200 || out_data !== mem[14'h0200]) begin
      n_err++; $display("FAIL mid_head: valid %b addr %h want 1 0200", out_valid, out_addr); end
  endtask

  task automatic test_halt();
    logic [13:0] held;
    int guard;
    step(1'b1, 14'h0300, 1'b0, 1'b1);
    repeat (4) step(1'b0, 14'h0, 1'b0, 1'b1);
    held  = m_pc;
    guard = 0;
    step(1'b0, 14'h0, 1'b1, 1'b1);
    while (out_valid === 1'b1 && guard < 10) begin
      n_vec++; if (busy !== 1'b0 || out_addr !== q_addr[0]) begin
        n_err++; $display("FAIL halt_drain: busy %b addr %h want 0 %h", busy, out_addr, q_addr[0]); end
      step(1'b0, 14'h0, 1'b1, 1'b1);
      guard++;
    end
    held = m_pc;
    n_vec++; if (out_valid !== 1'b0 || guard >= 10) begin
      n_err++; $display("FAIL halt_empty: valid %b cycles %0d want 0 <10", out_valid, guard); end
    n_vec++; if (imem_addra !== held) begin n_err++; $display("FAIL halt_pc: got %h want %h", imem_addra, held); end
    step(1'b0, 14'h0, 1'b0, 1'b1);
    step(1'b0, 14'h0, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b1 || out_addr !== held || busy !== 1'b1) begin
      n_err++; $display("FAIL halt_resume: valid %b addr %h busy %b want 1 %h 1", out_valid, out_addr, busy, held); end
  endtask

  task automatic test_async_reset();
    step(1'b1, 14'h0040, 1'b0, 1'b0);
    repeat (4) step(1'b0, 14'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL arst_out: valid %b busy %b want 0 0", out_valid, busy); end
    n_vec++; if (fetch_cnt !== 32'd0 || redir_cnt !== 32'd0 || imem_addra !== 14'd0) begin
      n_err++; $display("FAIL arst_cnt: %0d/%0d pc %h want 0/0 0000", fetch_cnt, redir_cnt, imem_addra); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 14'h0, 1'b0, 1'b1);
      n_vec++; if (out_valid !== 1'b0 || busy !== 1'b0 || imem_addra !== 14'd0) begin
        n_err++; $display("FAIL arst_idle%0d: valid %b busy %b pc %h want 0 0 0000", k, out_valid, busy, imem_addra); end
    end
  endtask

  task automatic test_random();
    logic hlt, rdy, rd;
    hlt = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(29) == 0) hlt = ~hlt;
      rdy = ($urandom_range(9) < 7);
      rd  = ($urandom_range(39) == 0) || (c == 0);
      step(rd, 14'($urandom), hlt, rdy);
      n_vec++; if (out_valid !== e_valid()) begin
        n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", c, out_valid, e_valid()); end
      if (e_valid()) begin
        n_vec++; if (out_addr !== q_addr[0] || out_data !== q_data[0]) begin
          n_err++; $display("FAIL rnd_head@%0d: got %h/%h want %h/%h", c, out_addr, out_data, q_addr[0], q_data[0]); end
      end
      n_vec++; if (imem_addra !== m_pc || imem_addrb !== 14'(m_pc + 14'd1) || busy !== (m_state == S_RUN)) begin
        n_err++; $display("FAIL rnd_pc@%0d: got %h/%h busy %b want %h", c, imem_addra, imem_addrb, busy, m_pc); end
      n_vec++; if (fetch_cnt !== e_fc() || redir_cnt !== e_rc()) begin
        n_err++; $display("FAIL rnd_cnt@%0d: got %0d/%0d want %0d/%0d", c, fetch_cnt, redir_cnt, e_fc(), e_rc()); end
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = {32'($urandom), 32'(i)};
    model_reset();
    test_reset();
    test_sequential();
    test_backpressure();
    test_wrap();
    test_mid_redirect();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
